// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, status codes, register-none id, fetch helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    // Longest instruction is 10 bytes; the memory read port exposes this many.
    localparam int FETCH_WINDOW = 10;

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_t;

    function automatic logic need_regids(input logic [3:0] ic);
        return ic inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
    endfunction

    function automatic logic need_valc(input logic [3:0] ic);
        return ic inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    endfunction

endpackage

// File: rtl/fetch_pc_if.sv
// Fetch bus: imem loader port, execute/memory feedback, and decoded fetch outputs.
// Latency: n/a (signal bundle only).
// Backpressure: optional stall (only when FETCH_STALL_EN is defined).
// Modports: master = environment driving loader/feedback; slave = fetch_pc.
import y86_pkg::*;

interface fetch_pc_if;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic        cnd;
    logic [63:0] valM;
`ifdef FETCH_STALL_EN
    logic        stall;
`endif
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    stat_t       stat;

    modport master (
`ifdef FETCH_STALL_EN
        output stall,
`endif
        output imem_we, imem_waddr, imem_wdata, cnd, valM,
        input  pc, icode, ifun, rA, rB, valC, valP, stat
    );

    modport slave (
`ifdef FETCH_STALL_EN
        input  stall,
`endif
        input  imem_we, imem_waddr, imem_wdata, cnd, valM,
        output pc, icode, ifun, rA, rB, valC, valP, stat
    );
endinterface

// File: rtl/fetch_pc_imem.sv
// Byte-wide instruction memory: one synchronous write port, a combinational 10-byte read window.
// Latency: write lands at the clk edge; read window is zero-latency from raddr.
// Backpressure: none; out-of-range writes are dropped, out-of-range reads return 8'h00.
// Ports: clk, we/waddr/wdata (loader), raddr (window base), window[i] = byte at raddr+i.
import y86_pkg::*;

module imem_byte #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [63:0]                   waddr,
    input  logic [7:0]                    wdata,
    input  logic [63:0]                   raddr,
    output logic [FETCH_WINDOW-1:0][7:0]  window
);
    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

    // No reset: contents survive rst, and a write concurrent with rst still lands.
    logic [7:0] mem [IMEM_BYTES];

    always_ff @(posedge clk) begin
        if (we && (waddr < 64'(IMEM_BYTES))) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Each window byte is range-checked on its own full 64-bit address (wrapping add),
    // so a window that straddles the top of memory reads zeros past the end.
    for (genvar i = 0; i < FETCH_WINDOW; i++) begin : g_rd
        logic [63:0] addr;
        assign addr      = raddr + 64'(i);
        assign window[i] = (addr < 64'(IMEM_BYTES)) ? mem[addr[AW-1:0]] : 8'h00;
    end
endmodule

// File: rtl/fetch_pc.sv
// Y86-64 SEQ fetch: PC register, instruction split, valP, next-PC select and sticky status FSM.
// Latency: decoded outputs are combinational from pc and memory; pc/stat update at each clk edge.
// Backpressure: stall (FETCH_STALL_EN defined) holds pc and stat; otherwise pc advances every edge while AOK.
// Ports: clk, rst (async active-high), bus (fetch_pc_if.slave): loader write, cnd/valM feedback,
//        pc/icode/ifun/rA/rB/valC/valP/stat outputs. Optional macro: FETCH_STALL_EN.
import y86_pkg::*;

module fetch_pc #(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] PC_RESET   = 64'd0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_pc_if.slave     bus
);
    logic [63:0]                  pc_q;
    stat_t                        stat_q;
    logic [FETCH_WINDOW-1:0][7:0] win;

    imem_byte #(.IMEM_BYTES(IMEM_BYTES)) u_imem (
        .clk    (clk),
        .we     (bus.imem_we),
        .waddr  (bus.imem_waddr),
        .wdata  (bus.imem_wdata),
        .raddr  (pc_q),
        .window (win)
    );

    logic [3:0]  icode_raw;
    logic [3:0]  ifun_raw;
    logic        has_regids;
    logic        has_valc;
    logic [3:0]  instr_len;
    logic [63:0] valc_raw;
    logic [63:0] valp_raw;
    logic [63:0] last_byte;
    logic [63:0] next_pc;
    logic        adr_fault;
    logic        ins_fault;
    logic        hold;
    logic        running;

    assign icode_raw  = win[0][7:4];
    assign ifun_raw   = win[0][3:0];
    assign has_regids = need_regids(icode_raw);
    assign has_valc   = need_valc(icode_raw);

    // Packed slice keeps little-endian order: the lowest window byte is valC[7:0].
    assign valc_raw  = !has_valc ? 64'd0 : (has_regids ? win[9:2] : win[8:1]);
    assign instr_len = 4'd1 + {3'd0, has_regids} + (has_valc ? 4'd8 : 4'd0);
    assign valp_raw  = pc_q + {60'd0, instr_len};
    assign last_byte = pc_q + {60'd0, instr_len} - 64'd1;

    // The pc check catches a pc so close to 2^64 that last_byte wraps back into range.
    assign adr_fault = (pc_q >= 64'(IMEM_BYTES)) || (last_byte >= 64'(IMEM_BYTES));

    always_comb begin
        ins_fault = 1'b0;
        case (icode_raw)
            I_RRMOVQ, I_JXX:                      ins_fault = (ifun_raw > 4'd6);
            I_OPQ:                                ins_fault = (ifun_raw > 4'd3);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ,
            I_MRMOVQ, I_CALL, I_RET, I_PUSHQ,
            I_POPQ:                               ins_fault = (ifun_raw != 4'd0);
            default:                              ins_fault = 1'b1;
        endcase
    end

    always_comb begin
        next_pc = valp_raw;
        case (icode_raw)
            I_CALL:  next_pc = valc_raw;
            I_JXX:   next_pc = bus.cnd ? valc_raw : valp_raw;
            I_RET:   next_pc = bus.valM;
            default: next_pc = valp_raw;
        endcase
    end

`ifdef FETCH_STALL_EN
    assign hold = bus.stall;
`else
    assign hold = 1'b0;
`endif

    // Status FSM: a faulting instruction is retired by moving stat off AOK instead of
    // advancing pc, so pc stays on the faulting instruction. ADR outranks INS outranks HLT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= PC_RESET;
            stat_q <= S_AOK;
        end else if ((stat_q == S_AOK) && !hold) begin
            if (adr_fault) begin
                stat_q <= S_ADR;
            end else if (ins_fault) begin
                stat_q <= S_INS;
            end else if (icode_raw == I_HALT) begin
                stat_q <= S_HLT;
            end else begin
                pc_q <= next_pc;
            end
        end
    end

    // Once stopped, decode sees a stream of nops so nothing downstream acts on stale bytes.
    assign running   = (stat_q == S_AOK);
    assign bus.pc    = pc_q;
    assign bus.stat  = stat_q;
    assign bus.icode = running ? icode_raw : I_NOP;
    assign bus.ifun  = running ? ifun_raw  : 4'd0;
    assign bus.rA    = (running && has_regids) ? win[1][7:4] : REG_NONE;
    assign bus.rB    = (running && has_regids) ? win[1][3:0] : REG_NONE;
    assign bus.valC  = running ? valc_raw : 64'd0;
    assign bus.valP  = valp_raw;
endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed programs plus randomized byte images.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: exercises stall when FETCH_STALL_EN is defined.
import y86_pkg::*;

module tb_fetch_pc;
    localparam int IMEM = 1024;

    // Highest legal ifun per icode; -1 marks an icode that is never legal.
    localparam int MAXF [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
    localparam logic [7:0] LEGAL [27] = '{
        8'h00, 8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h30,
        8'h40, 8'h50, 8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h71, 8'h72, 8'h73,
        8'h74, 8'h75, 8'h76, 8'h80, 8'h90, 8'hA0, 8'hB0};

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_pc_if bus();

    fetch_pc #(.IMEM_BYTES(IMEM), .PC_RESET(64'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_mem [IMEM];
    logic [63:0] m_pc;
    int          m_stat;
    logic [7:0]  prog [$];

    typedef struct {
        int          icode;
        int          ifun;
        int          ra;
        int          rb;
        logic [63:0] valc;
        logic [63:0] valp;
        bit          adr;
        bit          bad;
    } dec_t;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(logic [63:0] a);
        if (a < 64'(IMEM)) return m_mem[int'(a)];
        return 8'h00;
    endfunction

    function automatic dec_t decode_model();
        dec_t d;
        logic [7:0] b0;
        logic [7:0] b1;
        bit regs;
        bit cst;
        int len;
        int off;
        b0 = rd(m_pc);
        b1 = rd(m_pc + 64'd1);
        d.icode = int'(b0) / 16;
        d.ifun  = int'(b0) % 16;
        regs = d.icode inside {2, 3, 4, 5, 6, 10, 11};
        cst  = d.icode inside {3, 4, 5, 7, 8};
        len  = 1 + (regs ? 1 : 0) + (cst ? 8 : 0);
        off  = regs ? 2 : 1;
        d.ra = regs ? int'(b1) / 16 : 15;
        d.rb = regs ? int'(b1) % 16 : 15;
        d.valc = 64'd0;
        if (cst) begin
            for (int k = 0; k < 8; k++) begin
                d.valc = d.valc + (64'(rd(m_pc + 64'(off + k))) << (8 * k));
            end
        end
        d.valp = m_pc + 64'(len);
        d.adr  = (m_pc >= 64'(IMEM)) || ((m_pc + 64'(len) - 64'd1) >= 64'(IMEM));
        d.bad  = d.ifun > MAXF[d.icode];
        return d;
    endfunction

    task automatic check_all(string t);
        dec_t d;
        bit ok;
        d  = decode_model();
        ok = (m_stat == 1);
        check({t, ":pc"},    bus.pc, m_pc);
        check({t, ":stat"},  64'(bus.stat), 64'(m_stat));
        check({t, ":icode"}, 64'(bus.icode), ok ? 64'(d.icode) : 64'd1);
        check({t, ":ifun"},  64'(bus.ifun),  ok ? 64'(d.ifun)  : 64'd0);
        check({t, ":rA"},    64'(bus.rA),    ok ? 64'(d.ra)    : 64'd15);
        check({t, ":rB"},    64'(bus.rB),    ok ? 64'(d.rb)    : 64'd15);
        check({t, ":valC"},  bus.valC,       ok ? d.valc       : 64'd0);
        if (ok) check({t, ":valP"}, bus.valP, d.valp);
    endtask

    // Advance one clock edge; called and returns at a falling edge.
    task automatic tick();
        logic [63:0] npc;
        int nst;
        bit hold;
        dec_t d;
        npc  = m_pc;
        nst  = m_stat;
        hold = 1'b0;
`ifdef FETCH_STALL_EN
        hold = bus.stall;
`endif
        if (rst) begin
            npc = 64'd0;
            nst = 1;
        end else if (m_stat == 1 && !hold) begin
            d = decode_model();
            if (d.adr)             nst = 3;
            else if (d.bad)        nst = 4;
            else if (d.icode == 0) nst = 2;
            else if (d.icode == 8) npc = d.valc;
            else if (d.icode == 7) npc = bus.cnd ? d.valc : d.valp;
            else if (d.icode == 9) npc = bus.valM;
            else                   npc = d.valp;
        end
        @(posedge clk);
        if (bus.imem_we && bus.imem_waddr < 64'(IMEM)) m_mem[int'(bus.imem_waddr)] = bus.imem_wdata;
        m_pc   = npc;
        m_stat = nst;
        @(negedge clk);
    endtask

    task automatic load(int a, logic [7:0] v);
        bus.imem_we    = 1'b1;
        bus.imem_waddr = 64'(a);
        bus.imem_wdata = v;
        tick();
        bus.imem_we    = 1'b0;
    endtask

    task automatic load_prog(int base);
        foreach (prog[i]) load(base + i, prog[i]);
    endtask

    task automatic rst_on();
        rst    = 1'b1;
        m_pc   = 64'd0;
        m_stat = 1;
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return LEGAL[$urandom_range(0, 26)];
        if (r < 8) return 8'($urandom_range(0, 127));
        return 8'($urandom);
    endfunction

    initial begin
        bus.imem_we    = 1'b0;
        bus.imem_waddr = 64'd0;
        bus.imem_wdata = 8'd0;
        bus.cnd        = 1'b0;
        bus.valM       = 64'd0;
`ifdef FETCH_STALL_EN
        bus.stall      = 1'b0;
`endif
        rst_on();
        @(negedge clk);
        check("reset_pc",   bus.pc, 64'd0);
        check("reset_stat", 64'(bus.stat), 64'd1);

        for (int a = 0; a < IMEM; a++) load(a, 8'h00);

        // irmovq $0x100,%rax then halt
        prog = '{8'h30, 8'hF0, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(0);
        rst = 1'b0;
        check("t1_icode", 64'(bus.icode), 64'd3);
        check("t1_rA",    64'(bus.rA),    64'hF);
        check("t1_rB",    64'(bus.rB),    64'd0);
        check("t1_valC",  bus.valC,       64'h100);
        check("t1_valP",  bus.valP,       64'd10);
        check_all("t1a");
        tick();
        check("t1_pc10",  bus.pc, 64'd10);
        check("t1_halt",  64'(bus.icode), 64'd0);
        tick();
        check("t1_stat",  64'(bus.stat), 64'd2);
        check("t1_pcfrz", bus.pc, 64'd10);
        check("t1_nop",   64'(bus.icode), 64'd1);
        tick();
        check_all("t1b");

        // jne 0x20, taken then (after reset) not taken; reset lands mid-cycle at pc=0x20
        rst_on();
        prog = '{8'h74, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(0);
        rst = 1'b0;
        bus.cnd = 1'b1;
        tick();
        check("t2_taken", bus.pc, 64'h20);
        rst_on();
        #1;
        check("t6_pc",   bus.pc, 64'd0);
        check("t6_stat", 64'(bus.stat), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.cnd = 1'b0;
        tick();
        check("t2_nottaken", bus.pc, 64'd9);

        // call 0x40 ; at 0x40 ret. Also an out-of-range write must not alias onto byte 0.
        rst_on();
        prog = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(0);
        load(8'h40, 8'h90);
        load(IMEM, 8'hFF);
        rst = 1'b0;
        check("t3_noalias", 64'(bus.icode), 64'd8);
        tick();
        check("t3_call", bus.pc, 64'h40);
        check("t3_valP", bus.valP, 64'h41);
        bus.valM = 64'd9;
        tick();
        check("t3_ret", bus.pc, 64'd9);
        bus.valM = 64'd0;

        // illegal icode C
        rst_on();
        load(0, 8'hC0);
        rst = 1'b0;
        check("t4_rawic", 64'(bus.icode), 64'hC);
        tick();
        check("t4_stat", 64'(bus.stat), 64'd4);
        check("t4_pc",   bus.pc, 64'd0);
        check("t4_ic",   64'(bus.icode), 64'd1);
        check_all("t4a");
        // OPq with ifun 5
        rst_on();
        load(0, 8'h65);
        rst = 1'b0;
        tick();
        check("t4_opq", 64'(bus.stat), 64'd4);

        // call to IMEM-4 where a 10-byte irmovq runs past the end
        rst_on();
        prog = '{8'h80, 8'hFC, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_prog(0);
        prog = '{8'h30, 8'hF0, 8'h00, 8'h00};
        load_prog(IMEM - 4);
        rst = 1'b0;
        tick();
        check("t5_pc",    bus.pc, 64'(IMEM - 4));
        check("t5_aok",   64'(bus.stat), 64'd1);
        tick();
        check("t5_stat",  64'(bus.stat), 64'd3);
        check("t5_pcfrz", bus.pc, 64'(IMEM - 4));

`ifdef FETCH_STALL_EN
        rst_on();
        for (int a = 0; a < 20; a++) load(a, 8'h10);
        rst = 1'b0;
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t7_hold", bus.pc, 64'd0);
        end
        bus.stall = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t7_run", bus.pc, 64'(k));
        end
`endif

        // Random byte images, random cnd/valM, occasional writes into the running image.
        for (int run = 0; run < 40; run++) begin
            rst_on();
            for (int a = 0; a < 128; a++) load(a, rand_byte());
            rst = 1'b0;
            for (int c = 0; c < 25; c++) begin
                check_all("rnd");
                bus.cnd  = 1'($urandom_range(0, 1));
                bus.valM = 64'($urandom_range(0, 140));
                bus.imem_we    = ($urandom_range(0, 7) == 0);
                bus.imem_waddr = 64'($urandom_range(0, 127));
                bus.imem_wdata = rand_byte();
`ifdef FETCH_STALL_EN
                bus.stall = ($urandom_range(0, 3) == 0);
`endif
                tick();
            end
            bus.imem_we = 1'b0;
`ifdef FETCH_STALL_EN
            bus.stall = 1'b0;
`endif
            check_all("rnd_end");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
